dcm_multi_axis_ctrl: RTL and testbench

Parametrised N-channel DC-motor position/speed controller. It is the successor core behind the SPI register front-end in dcmctrl. Per channel it holds:
- target speed (PWM duty)
- target position
- a signed encoder-pulse position counter
- a run/brake/fault state machine driving the H-bridge left/right/reset pins.

Generalises channel count, position width and PWM resolution. Adds braking, overshoot handling, over-temperature throttling and latched fault recovery.

---
 rtl/dcm_multi_axis_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dcm_multi_axis_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_multi_axis_ctrl.sv
// rtl/dcm_multi_axis_ctrl.sv - N-channel DC-motor position/speed controller (optional stall detect: STALL_DETECT_EN)
module dcm_multi_axis_ctrl #(
   parameter int NUM_CH       = 8,
   parameter int CH_AW        = 3,
   parameter int POS_W        = 24,
   parameter int PWM_W        = 8,
   parameter int BRAKE_CYCLES = 1024,
   parameter int STALL_CYCLES = 2000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CH_AW+1:0]  wr_addr,
   input  logic [POS_W-1:0]  wr_data,
   input  logic [CH_AW-1:0]  rd_ch,
   output logic [POS_W-1:0]  rd_pos,
   output logic [4:0]        rd_status,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] motor_left,
   output logic [NUM_CH-1:0] motor_right,
   output logic [NUM_CH-1:0] motor_reset,
   input  logic [NUM_CH-1:0] motor_pulse,
   input  logic [NUM_CH-1:0] motor_fault,
   input  logic [NUM_CH-1:0] motor_otw
);

   localparam int NSLOT = 2 ** CH_AW;
   localparam int BRK_W = $clog2(BRAKE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN_FWD = 3'd1,
      RUN_REV = 3'd2,
      BRAKE   = 3'd3,
      FAULT   = 3'd4
   } state_t;

   logic [NUM_CH-1:0] pulse_s1, pulse_s2, pulse_s3;
   logic [NUM_CH-1:0] fault_s1, fault_sync;
   logic [NUM_CH-1:0] otw_s1, otw_sync;
   logic [PWM_W-1:0]  pwm_cnt;
   logic [CH_AW-1:0]  wr_ch;
   logic [1:0]        wr_reg;

   // Readback slots are padded to the full address space so rd_ch never indexes past the end
   logic [POS_W-1:0]  pos_arr   [NSLOT];
   logic [2:0]        state_arr [NSLOT];
   logic [NSLOT-1:0]  stall_vec;
   logic [NSLOT-1:0]  otw_vec;

   assign wr_ch  = wr_addr[CH_AW+1:2];
   assign wr_reg = wr_addr[1:0];

   // Two-flop synchronisers for the asynchronous driver pins, third pulse flop for edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pulse_s1   <= '0;
         pulse_s2   <= '0;
         pulse_s3   <= '0;
         fault_s1   <= '0;
         fault_sync <= '0;
         otw_s1     <= '0;
         otw_sync   <= '0;
      end else begin
         pulse_s1   <= motor_pulse;
         pulse_s2   <= pulse_s1;
         pulse_s3   <= pulse_s2;
         fault_s1   <= motor_fault;
         fault_sync <= fault_s1;
         otw_s1     <= motor_otw;
         otw_sync   <= otw_s1;
      end
   end

   // Shared free-running PWM counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pwm_cnt <= '0;
      else        pwm_cnt <= pwm_cnt + PWM_W'(1);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t             state, state_nxt;
      logic [PWM_W-1:0]   speed;
      logic [POS_W-1:0]   target;
      logic [POS_W-1:0]   pos;
      logic               enable;
      logic               dir;
      logic [BRK_W-1:0]   brk_cnt;
      logic               wr_hit, wr_ctrl, clr_fault, zero_pos;
      logic               pulse_evt, phase, stall_hit, stall_flag;
      logic [PWM_W-1:0]   duty;
      logic               drv_l, drv_r, drv_rst, drv_busy;

      assign wr_hit    = wr_en && (wr_ch == CH_AW'(c));
      assign wr_ctrl   = wr_hit && (wr_reg == 2'd2);
      assign clr_fault = wr_ctrl && wr_data[1];
      assign zero_pos  = wr_ctrl && wr_data[2];
      assign pulse_evt = pulse_s2[c] & ~pulse_s3[c];
      assign duty      = otw_sync[c] ? (speed >> 1) : speed;
      assign phase     = (pwm_cnt < duty);

`ifdef STALL_DETECT_EN
      localparam int STL_W = $clog2(STALL_CYCLES + 1);
      logic [STL_W-1:0] stall_cnt;
      logic             running;

      assign running   = (state == RUN_FWD) || (state == RUN_REV);
      assign stall_hit = running && !pulse_evt && (stall_cnt == STL_W'(STALL_CYCLES - 1));

      // Clocks since the last pulse while driving; restarts on any pulse or state change
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
         end else begin
            if (pulse_evt || (state_nxt != state) || !running) stall_cnt <= '0;
            else                                               stall_cnt <= stall_cnt + STL_W'(1);
            if (stall_hit && !fault_sync[c])                   stall_flag <= 1'b1;
            else if (wr_ctrl && (wr_data[1] || wr_data[2]))    stall_flag <= 1'b0;
         end
      end
`else
      assign stall_hit  = 1'b0;
      assign stall_flag = 1'b0;
`endif

      // Channel registers, position counter and direction latch
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            speed  <= '0;
            target <= '0;
            enable <= 1'b0;
            pos    <= '0;
            dir    <= 1'b0;
         end else begin
            if (wr_hit) begin
               case (wr_reg)
                  2'd0:    speed  <= wr_data[PWM_W-1:0];
                  2'd1:    target <= wr_data;
                  2'd2:    enable <= wr_data[0];
                  default: ;
               endcase
            end
            // Zeroing wins over a coincident pulse, which is dropped
            if (zero_pos)       pos <= '0;
            else if (pulse_evt) pos <= dir ? pos - POS_W'(1) : pos + POS_W'(1);
            if (state == IDLE && state_nxt == RUN_FWD)      dir <= 1'b0;
            else if (state == IDLE && state_nxt == RUN_REV) dir <= 1'b1;
         end
      end

      // State register and brake timer
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state   <= IDLE;
            brk_cnt <= '0;
         end else begin
            state   <= state_nxt;
            brk_cnt <= (state == BRAKE) ? brk_cnt + BRK_W'(1) : '0;
         end
      end

      // Next state and H-bridge drive; a synced fault overrides everything
      always_comb begin
         state_nxt = state;
         drv_l     = 1'b0;
         drv_r     = 1'b0;
         drv_rst   = 1'b0;
         drv_busy  = 1'b0;
         case (state)
            IDLE: begin
               if (enable && (pos != target))
                  state_nxt = ($signed(target) > $signed(pos)) ? RUN_FWD : RUN_REV;
            end
            RUN_FWD: begin
               drv_l    = phase;
               drv_busy = 1'b1;
               if (stall_hit)                                      state_nxt = FAULT;
               else if (!enable || $signed(pos) >= $signed(target)) state_nxt = BRAKE;
            end
            RUN_REV: begin
               drv_r    = phase;
               drv_busy = 1'b1;
               if (stall_hit)                                      state_nxt = FAULT;
               else if (!enable || $signed(pos) <= $signed(target)) state_nxt = BRAKE;
            end
            BRAKE: begin
               drv_l    = 1'b1;
               drv_r    = 1'b1;
               drv_busy = 1'b1;
               if (brk_cnt == BRK_W'(BRAKE_CYCLES - 1)) state_nxt = IDLE;
            end
            FAULT: begin
               drv_rst = 1'b1;
               if (clr_fault) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
         if (fault_sync[c]) state_nxt = FAULT;
      end

      assign motor_left[c]  = drv_l;
      assign motor_right[c] = drv_r;
      assign motor_reset[c] = drv_rst;
      assign busy[c]        = drv_busy;
      assign pos_arr[c]     = pos;
      assign state_arr[c]   = state;
      assign stall_vec[c]   = stall_flag;
      assign otw_vec[c]     = otw_sync[c];
   end

   for (genvar c = NUM_CH; c < NSLOT; c++) begin : g_pad
      assign pos_arr[c]   = '0;
      assign state_arr[c] = '0;
      assign stall_vec[c] = 1'b0;
      assign otw_vec[c]   = 1'b0;
   end

   assign rd_pos    = pos_arr[rd_ch];
   assign rd_status = {otw_vec[rd_ch], stall_vec[rd_ch], state_arr[rd_ch]};

endmodule

// File: tb/tb_dcm_multi_axis_ctrl.sv
// tb/tb_dcm_multi_axis_ctrl.sv - directed self-checking bench for dcm_multi_axis_ctrl
module tb_dcm_multi_axis_ctrl;

   localparam int NUM_CH = 2;
   localparam int CH_AW  = 2;
   localparam int POS_W  = 24;
   localparam int PWM_W  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [CH_AW+1:0]  wr_addr;
   logic [POS_W-1:0]  wr_data;
   logic [CH_AW-1:0]  rd_ch;
   logic [POS_W-1:0]  rd_pos;
   logic [4:0]        rd_status;
   logic [NUM_CH-1:0] busy, motor_left, motor_right, motor_reset;
   logic [NUM_CH-1:0] motor_pulse, motor_fault, motor_otw;

   int n_chk = 0;
   int n_bad = 0;
   int cnt, nb, both;

   always #5 clk = ~clk;

   dcm_multi_axis_ctrl #(
      .NUM_CH(NUM_CH), .CH_AW(CH_AW), .POS_W(POS_W), .PWM_W(PWM_W),
      .BRAKE_CYCLES(16), .STALL_CYCLES(1000)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_ch(rd_ch), .rd_pos(rd_pos), .rd_status(rd_status), .busy(busy),
      .motor_left(motor_left), .motor_right(motor_right), .motor_reset(motor_reset),
      .motor_pulse(motor_pulse), .motor_fault(motor_fault), .motor_otw(motor_otw)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reg_wr(input int ch, input int r, input logic [POS_W-1:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = {CH_AW'(ch), 2'(r)};
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse(input int ch);
      @(negedge clk);
      motor_pulse[ch] = 1'b1;
      repeat (2) @(negedge clk);
      motor_pulse[ch] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic sel(input int ch);
      rd_ch = CH_AW'(ch);
      #1;
   endtask

   task automatic wait_state(input int ch, input logic [2:0] st, input int max, input string tag);
      int n;
      n = 0;
      sel(ch);
      while (rd_status[2:0] != st && n < max) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, rd_status[2:0], st);
   endtask

   task automatic measure(input int ch, input bit rev, output int c);
      c = 0;
      repeat (256) begin
         @(negedge clk);
         if (rev ? motor_right[ch] : motor_left[ch]) c++;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_ch = '0;
      motor_pulse = '0; motor_fault = '0; motor_otw = '0;
      repeat (3) @(negedge clk);
      chk("rst_pos", rd_pos, 0);
      chk("rst_status", rd_status, 0);
      chk("rst_outs", {busy, motor_left, motor_right, motor_reset}, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_outs", {busy, motor_left, motor_right, motor_reset}, 0);

      // Forward run on ch0
      reg_wr(0, 0, 100);
      reg_wr(0, 1, 20);
      reg_wr(0, 2, 1);
      wait_state(0, 3'd1, 5, "fwd_run");
      chk("fwd_busy", busy[0], 1);
      measure(0, 0, cnt);
      chk("fwd_duty", cnt, 100);
      chk("ch1_quiet", {motor_left[1], motor_right[1], busy[1], motor_reset[1]}, 0);
      repeat (20) pulse(0);
      wait_state(0, 3'd3, 10, "fwd_brake");
      nb = 0; both = 0;
      while (rd_status[2:0] == 3'd3 && nb < 100) begin
         nb++;
         if (motor_left[0] && motor_right[0]) both++;
         @(negedge clk);
         #1;
      end
      chk("brake_len", nb, 16);
      chk("brake_drive", both, 16);
      chk("fwd_idle", rd_status[2:0], 0);
      chk("fwd_pos", rd_pos, 20);
      chk("fwd_busy_end", busy[0], 0);

      // Overshoot during brake, corrected by a reverse run
      reg_wr(0, 1, 25);
      wait_state(0, 3'd1, 5, "os_run");
      repeat (5) pulse(0);
      repeat (2) pulse(0);
      chk("os_brake", rd_status[2:0], 3);
      chk("os_pos", rd_pos, 27);
      wait_state(0, 3'd2, 40, "os_rev");
      repeat (2) pulse(0);
      wait_state(0, 3'd0, 40, "os_idle");
      chk("os_settle", rd_pos, 25);

      // Fault entry, ignored clear, real clear
      reg_wr(0, 1, 100);
      wait_state(0, 3'd1, 5, "flt_run");
      @(negedge clk);
      motor_fault[0] = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("flt_latency", rd_status[2:0], 1);
      @(negedge clk);
      #1;
      chk("flt_state", rd_status[2:0], 4);
      chk("flt_pins", {motor_reset[0], motor_left[0], motor_right[0], busy[0]}, 4'b1000);
      reg_wr(0, 2, 3);
      #1;
      chk("flt_clr_high", rd_status[2:0], 4);
      motor_fault[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("flt_hold", rd_status[2:0], 4);
      reg_wr(0, 2, 3);
      #1;
      chk("flt_cleared", rd_status[2:0], 0);
      wait_state(0, 3'd1, 5, "flt_resume");

      // Over-temperature halves the duty
      reg_wr(0, 0, 200);
      motor_otw[0] = 1'b1;
      repeat (3) @(negedge clk);
      measure(0, 0, cnt);
      chk("otw_duty", cnt, 100);
      #1;
      chk("otw_status", rd_status[4], 1);
      motor_otw[0] = 1'b0;
      repeat (3) @(negedge clk);
      measure(0, 0, cnt);
      chk("full_duty", cnt, 200);
      reg_wr(0, 2, 0);
      wait_state(0, 3'd0, 40, "stop_idle");

      // Reverse run with wrap on ch1, full speed
      reg_wr(1, 0, 255);
      reg_wr(1, 2, 5);
      reg_wr(1, 1, 24'hFFFFF6);
      wait_state(1, 3'd2, 5, "rev_run");
      measure(1, 1, cnt);
      chk("rev_duty", cnt, 255);
      chk("rev_left", motor_left[1], 0);
      repeat (10) pulse(1);
      wait_state(1, 3'd0, 40, "rev_idle");
      chk("rev_pos", rd_pos, 24'hFFFFF6);

      // Writes to a nonexistent channel
      reg_wr(3, 1, 24'h000123);
      reg_wr(3, 2, 24'h000004);
      repeat (4) @(negedge clk);
      sel(1);
      chk("ch3_ch1_state", rd_status[2:0], 0);
      chk("ch3_ch1_pos", rd_pos, 24'hFFFFF6);
      sel(0);
      chk("ch3_ch0_state", rd_status[2:0], 0);
      chk("ch3_ch0_pos", rd_pos, 25);

      // Zero-position coincident with a pulse event
      @(negedge clk);
      motor_pulse[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = {CH_AW'(1), 2'd2}; wr_data = 24'd5;
      @(negedge clk);
      wr_en = 1'b0;
      motor_pulse[1] = 1'b0;
      sel(1);
      chk("zero_vs_pulse", rd_pos, 0);

      // Stall behaviour with no encoder pulses
      wait_state(1, 3'd2, 5, "stall_run");
`ifdef STALL_DETECT_EN
      wait_state(1, 3'd4, 1100, "stall_fault");
      chk("stall_flag", rd_status[3], 1);
      reg_wr(1, 2, 3);
      #1;
      chk("stall_clr", rd_status[3], 0);
`else
      repeat (5000) @(negedge clk);
      #1;
      chk("nostall_run", rd_status[2:0], 2);
      chk("nostall_flag", rd_status[3], 0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
